// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - fetch stage states, constants and target alignment check
// Alignment rule depends on IF_FETCH_RVC_EN.
package fetch_pkg;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] ILEN_32  = 32'd4;
  localparam logic [31:0] ILEN_16  = 32'd2;

`ifdef IF_FETCH_RVC_EN
  localparam logic [1:0] ALIGN_MASK = 2'b01;
`else
  localparam logic [1:0] ALIGN_MASK = 2'b11;
`endif

  function automatic logic is_misaligned(input logic [1:0] i_lo);
    return |(i_lo & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/if_next_pc.sv
// rtl/if_next_pc.sv - instruction length decode and sequential PC adder
// With IF_FETCH_RVC_EN, a low opcode pair other than 2'b11 marks a 16-bit instruction.
module if_next_pc
  import fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_inst_lo,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_len;

`ifdef IF_FETCH_RVC_EN
  assign w_len = (i_inst_lo != 2'b11) ? ILEN_16 : ILEN_32;
`else
  logic [1:0] w_unused_inst_lo;
  assign w_unused_inst_lo = i_inst_lo;
  assign w_len = ILEN_32;
`endif

  // 32-bit add wraps naturally past 0xFFFF_FFFC
  assign o_next_pc = i_pc + w_len;

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: PC, RAM address issue, decode handshake
// Optional compressed-instruction support via IF_FETCH_RVC_EN.
module if_fetch
  import fetch_pkg::*;
#(
  parameter int          IMEM_ADDR_WIDTH = 14,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  input  logic [31:0]                i_imem_rdata,
  input  logic                       i_redirect,
  input  logic [31:0]                i_redirect_pc,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [31:0]                o_pc,
  output logic [31:0]                o_inst,
  output logic                       o_fault
);

  logic [1:0]  r_state;
  logic        r_req_valid;
  logic [31:0] r_req_pc;
  logic        r_valid;
  logic        r_fault;
  logic [31:0] r_pc;
  logic [31:0] r_inst;

  logic [31:0] w_next_pc;
  logic [31:0] w_issue_pc;
  logic        w_accept;
  logic        w_fetching;
  logic        w_bad_target;
  logic        w_unused_issue_hi;

  if_next_pc u_next_pc (
    .i_pc      (r_req_pc),
    .i_inst_lo (i_imem_rdata[1:0]),
    .o_next_pc (w_next_pc)
  );

  assign w_accept     = !r_valid || i_ready;
  assign w_fetching   = (r_state == ST_RUN) && r_req_valid;
  assign w_bad_target = is_misaligned(i_redirect_pc[1:0]);

  // Stalls replay the held request address so the RAM re-reads the same word
  always_comb begin
    w_issue_pc = r_req_pc;
    if (i_redirect) begin
      w_issue_pc = i_redirect_pc;
    end else if (r_state == ST_BOOT) begin
      w_issue_pc = RESET_PC;
    end else if (w_fetching && w_accept) begin
      w_issue_pc = w_next_pc;
    end
  end

  assign o_imem_addr       = w_issue_pc[IMEM_ADDR_WIDTH-1:0];
  assign w_unused_issue_hi = ^w_issue_pc[31:IMEM_ADDR_WIDTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_BOOT;
      r_req_valid <= 1'b0;
      r_req_pc    <= RESET_PC;
      r_valid     <= 1'b0;
      r_fault     <= 1'b0;
      r_pc        <= 32'h0;
      r_inst      <= 32'h0;
    end else if (i_redirect) begin
      r_req_pc <= i_redirect_pc;
      if (w_bad_target) begin
        r_state     <= ST_FAULT;
        r_req_valid <= 1'b0;
        r_valid     <= 1'b1;
        r_fault     <= 1'b1;
        r_pc        <= i_redirect_pc;
        r_inst      <= NOP_INST;
      end else begin
        r_state     <= ST_RUN;
        r_req_valid <= 1'b1;
        r_valid     <= 1'b0;
        r_fault     <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state     <= ST_RUN;
          r_req_valid <= 1'b1;
          r_req_pc    <= RESET_PC;
          if (r_valid && i_ready) r_valid <= 1'b0;
        end
        ST_RUN: begin
          if (r_req_valid && w_accept) begin
            r_valid  <= 1'b1;
            r_fault  <= 1'b0;
            r_pc     <= r_req_pc;
            r_inst   <= i_imem_rdata;
            r_req_pc <= w_next_pc;
          end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
          end
        end
        default: begin
          // FAULT: marker drains on handshake, then idle until a redirect
          if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_fault <= 1'b0;
          end
        end
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_fault = r_fault;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule
